pwm_sched: RTL and testbench
============================

PWM_SCHED -- requirements
Module: pwm_sched

Interface
REQ-001 SHALL have parameter: RAMP_STEP, 1, duty increment/decrement per PWM period during ramps (1..31).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_central  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 freezes the block.
- req_a  in  1  requester A wants the PWM.
- duty_a  in  5  requester A target duty.
- req_b  in  1  requester B wants the PWM.
- duty_b  in  5  requester B target duty.
- gnt_a  out  1  A owns the PWM this period.
- gnt_b  out  1  B owns the PWM this period.
- contador  out  5  free-running PWM phase counter.
- pwm_ref  out  5  applied duty reference.
- pwm_out  out  1  PWM waveform.
- period_end  out  1  last cycle of a PWM period.

Function
REQ-003 SHALL increment contador by 1 each clk while en=1, wrapping 31->0; period = 32 cycles.
REQ-004 SHALL drive period_end = en AND (contador==31), combinationally.
REQ-005 SHALL drive pwm_out = en AND (contador < pwm_ref); pwm_ref=0 gives constant low; pwm_ref=31 gives 31 high cycles out of 32.
REQ-006 SHALL update gnt_a, gnt_b, pwm_ref and FSM state only on clock edges where period_end=1, so changes take effect at contador=0.
REQ-007 SHALL arbitrate round-robin at each period_end:
- only one request: grant it.
- both requesting: grant the one not granted last.
- none requesting: drop both grants.
- last-served pointer updates only when a grant is issued.
REQ-008 SHALL never assert gnt_a and gnt_b together.
REQ-009 SHALL sample target = duty of the newly granted requester at the same period_end.
REQ-010 SHALL implement FSM states IDLE, RAMP_UP, RUN, RAMP_DOWN, all evaluated at period_end:
- IDLE: pwm_ref=0; any request -> RAMP_UP.
- RAMP_UP: pwm_ref = min(pwm_ref+RAMP_STEP, target); on reaching target -> RUN; no request -> RAMP_DOWN.
- RUN: pwm_ref=target; no request -> RAMP_DOWN.
- RAMP_DOWN: pwm_ref = max(pwm_ref-RAMP_STEP, 0); request -> RAMP_UP; pwm_ref reaching 0 -> IDLE.
REQ-011 SHALL ramp arithmetic:
- compute in 6 bits, saturating to 0..31, with no wrap.
- a target below pwm_ref during RAMP_UP SHALL load target directly and enter RUN.
REQ-012 SHALL, in RAMP_DOWN and IDLE, hold both grants low.
REQ-013 SHALL, while en=0:
- hold contador, state, grants and pwm_ref.
- drive pwm_out=0 and period_end=0.
REQ-014 SHALL ignore request and duty changes between period_end edges.

Reset
REQ-015 SHALL, on reset_central=1 at any time including mid-ramp:
- asynchronously clear contador, pwm_ref, gnt_a and gnt_b to 0.
- force state to IDLE.
- set the last-served pointer to B, so A wins the first tie.
REQ-016 SHALL, after reset release, start counting at the first enabled clk edge from contador=0.

Structure
REQ-017 SHALL place in shared package pwm_sched_pkg:
- state encoding (2-bit enum).
- PWM_W=5 and PWM_MAX=31.
REQ-018 SHALL instantiate one sub-module, pwm_rr_arb: 2-way round-robin arbiter with update strobe = period_end.

Verification
REQ-019 SHALL cover:
- Soft start: reset; req_a=1, duty_a=6, RAMP_STEP=1 -> gnt_a at first period_end; pwm_ref steps 1,2,...,6 over 6 periods; RUN from the sixth.
- Tie round-robin: req_a=req_b=1 in RUN, duty_a=6, duty_b=20 -> grants alternate A,B,A per period; pwm_ref alternates 6/20 in RUN.
- Release: drop all requests in RUN at pwm_ref=6 -> grants low; pwm_ref 5,4,...,0 over 6 periods; then IDLE; pwm_out constant low.
- Duty extremes: duty_a=31 -> pwm_out high 31 cycles per period; duty_a=0 -> pwm_out never high.
- Enable freeze: en=0 for 10 cycles at contador=17 -> contador holds 17, pwm_out=0, no period_end; resumes at 18.
- Async reset mid-ramp: reset_central pulse between clock edges -> all outputs 0 immediately; first tie after release grants A.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared widths, state encoding and saturating ramp helpers for pwm_sched
package pwm_sched_pkg;

  localparam int PWM_W = 5;
  localparam logic [PWM_W-1:0] PWM_MAX = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  // Step is at most 31, so a 6-bit sum overflows past PWM_MAX exactly when bit 5 is set.
  function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a,
                                               input logic [PWM_W:0] step);
    logic [PWM_W:0] s;
    s = {1'b0, a} + step;
    return s[PWM_W] ? PWM_MAX : s[PWM_W-1:0];
  endfunction

  function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a,
                                               input logic [PWM_W:0] step);
    return ({1'b0, a} <= step) ? '0 : (a - step[PWM_W-1:0]);
  endfunction

endpackage

// File: rtl/pwm_rr_arb.sv
// rtl/pwm_rr_arb.sv - two-way round-robin arbiter, grants change only on the update strobe
module pwm_rr_arb (
  input  logic clk,
  input  logic reset_central,
  input  logic update_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic nxt_a_o,
  output logic nxt_b_o
);

  logic gnt_a_q, gnt_b_q;
  logic last_b_q;

  // On a tie, A wins only if B was the last one served.
  always_comb begin
    nxt_a_o = req_a_i & (~req_b_i | last_b_q);
    nxt_b_o = req_b_i & ~nxt_a_o;
  end

  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
    end else if (update_i) begin
      gnt_a_q <= nxt_a_o;
      gnt_b_q <= nxt_b_o;
      if (nxt_a_o | nxt_b_o) last_b_q <= nxt_b_o;
    end
  end

  assign gnt_a_o = gnt_a_q;
  assign gnt_b_o = gnt_b_q;

endmodule

// File: rtl/pwm_sched.sv
// rtl/pwm_sched.sv - period-synchronous PWM scheduler with soft ramps and round-robin ownership
module pwm_sched
  import pwm_sched_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_central,
  input  logic             en,
  input  logic             req_a,
  input  logic [PWM_W-1:0] duty_a,
  input  logic             req_b,
  input  logic [PWM_W-1:0] duty_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [PWM_W-1:0] contador,
  output logic [PWM_W-1:0] pwm_ref,
  output logic             pwm_out,
  output logic             period_end
);

  localparam logic [PWM_W:0] STEP = RAMP_STEP[PWM_W:0];

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] ref_q, ref_d;
  logic [PWM_W-1:0] target_q, target_d;
  state_e           state_q, state_d;
  logic             nxt_a, nxt_b, any_req;
  logic [PWM_W-1:0] up_ref, dn_ref;

  assign period_end = en && (cnt_q == PWM_MAX);
  assign pwm_out    = en && (cnt_q < ref_q);
  assign contador   = cnt_q;
  assign pwm_ref    = ref_q;
  assign any_req    = req_a | req_b;

  pwm_rr_arb u_arb (
    .clk           (clk),
    .reset_central (reset_central),
    .update_i      (period_end),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .gnt_a_o       (gnt_a),
    .gnt_b_o       (gnt_b),
    .nxt_a_o       (nxt_a),
    .nxt_b_o       (nxt_b)
  );

  // The ramp targets the duty of whoever is being granted at this same boundary.
  assign target_d = nxt_a ? duty_a : (nxt_b ? duty_b : target_q);
  assign up_ref   = sat_add(ref_q, STEP);
  assign dn_ref   = sat_sub(ref_q, STEP);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    unique case (state_q)
      ST_IDLE: begin
        ref_d = '0;
        if (any_req) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!any_req) begin
          state_d = ST_RAMP_DOWN;
        end else if (up_ref >= target_d) begin
          ref_d   = target_d;
          state_d = ST_RUN;
        end else begin
          ref_d = up_ref;
        end
      end
      ST_RUN: begin
        ref_d = target_d;
        if (!any_req) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (any_req) begin
          state_d = ST_RAMP_UP;
        end else begin
          ref_d = dn_ref;
          if (dn_ref == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      cnt_q    <= '0;
      ref_q    <= '0;
      target_q <= '0;
      state_q  <= ST_IDLE;
    end else begin
      if (en) cnt_q <= cnt_q + 5'd1;
      if (period_end) begin
        state_q  <= state_d;
        ref_q    <= ref_d;
        target_q <= target_d;
      end
    end
  end

endmodule

// File: tb/tb_pwm_sched.sv
// tb/tb_pwm_sched.sv - per-period vector table with scoreboard plus freeze and async-reset sequences
module tb_pwm_sched;

  typedef struct {
    logic       ra;
    logic [4:0] da;
    logic       rb;
    logic [4:0] db;
    logic       ga;
    logic       gb;
    logic [4:0] rf;
    logic       frz;
  } vec_t;

  logic       clk;
  logic       reset_central;
  logic       en;
  logic       req_a, req_b;
  logic [4:0] duty_a, duty_b;
  logic       gnt_a, gnt_b;
  logic [4:0] contador, pwm_ref;
  logic       pwm_out, period_end;

  int total = 0;
  int bad = 0;
  int prev_ref = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  pwm_sched #(.RAMP_STEP(1)) dut (
    .clk           (clk),
    .reset_central (reset_central),
    .en            (en),
    .req_a         (req_a),
    .duty_a        (duty_a),
    .req_b         (req_b),
    .duty_b        (duty_b),
    .gnt_a         (gnt_a),
    .gnt_b         (gnt_b),
    .contador      (contador),
    .pwm_ref       (pwm_ref),
    .pwm_out       (pwm_out),
    .period_end    (period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic ra, input int da, input logic rb, input int db,
                              input logic ga, input logic gb, input int rf, input logic frz);
    vec_t v;
    v.ra = ra; v.da = da[4:0]; v.rb = rb; v.db = db[4:0];
    v.ga = ga; v.gb = gb; v.rf = rf[4:0]; v.frz = frz;
    vecs.push_back(v);
  endfunction

  // Drives one vector for a full PWM period and checks the state taken at its period_end edge.
  task automatic run_period(input vec_t v);
    vec_t e;
    int   hi;
    int   fz_bad;
    bit   found;
    req_a = v.ra; duty_a = v.da; req_b = v.rb; duty_b = v.db;
    exp_q.push_back(v);
    hi = 0;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (v.frz && contador == 5'd17) begin
        en = 1'b0;
        fz_bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (contador != 5'd17 || pwm_out || period_end) fz_bad++;
        end
        en = 1'b1;
        @(negedge clk);
        if (pwm_out) hi++;
        chk("freeze_hold_violations", fz_bad, 0);
        chk("freeze_resume_contador", contador, 18);
      end
      if (period_end) begin
        found = 1;
        chk("period_end_at_31", contador, 31);
        break;
      end
    end
    chk("period_end_seen", found, 1);
    chk("high_cycles", hi, prev_ref);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt_a", gnt_a, e.ga);
    chk("gnt_b", gnt_b, e.gb);
    chk("pwm_ref", pwm_ref, e.rf);
    chk("contador_wrap", contador, 0);
    chk("grant_mutex", gnt_a & gnt_b, 0);
    prev_ref = e.rf;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_contador"}, contador, 0);
    chk({tag, "_pwm_ref"}, pwm_ref, 0);
    chk({tag, "_gnt_a"}, gnt_a, 0);
    chk({tag, "_gnt_b"}, gnt_b, 0);
    chk({tag, "_pwm_out"}, pwm_out, 0);
    chk({tag, "_period_end"}, period_end, 0);
  endtask

  initial begin
    vec_t v;
    // soft start to 6
    add(1, 6, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) add(1, 6, 0, 0, 1, 0, k, 0);
    // tie: A was served last, so B first
    add(1, 6, 1, 20, 0, 1, 20, 0);
    add(1, 6, 1, 20, 1, 0, 6, 0);
    add(1, 6, 1, 20, 0, 1, 20, 0);
    add(1, 6, 1, 20, 1, 0, 6, 0);
    // release from RUN at 6, ramp down, then idle
    add(0, 6, 0, 20, 0, 0, 6, 0);
    for (int k = 5; k >= 0; k--) add(0, 6, 0, 20, 0, 0, k, 0);
    add(0, 6, 0, 20, 0, 0, 0, 0);
    // duty extremes, with an enable freeze inside a 31-high period
    add(1, 31, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 31; k++) add(1, 31, 0, 0, 1, 0, k, 0);
    add(1, 31, 0, 0, 1, 0, 31, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    reset_central = 1'b1;
    en = 1'b0;
    req_a = 1'b0; req_b = 1'b0; duty_a = '0; duty_b = '0;
    #23;
    check_all_zero("reset");
    reset_central = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_contador", contador, 0);
    en = 1'b1;

    foreach (vecs[i]) run_period(vecs[i]);

    // ramp toward 20, then reset asynchronously mid-ramp
    v.ra = 1; v.da = 5'd20; v.rb = 0; v.db = 5'd0; v.gb = 0; v.frz = 0; v.ga = 1;
    for (int k = 0; k <= 2; k++) begin
      v.rf = k[4:0];
      run_period(v);
    end
    @(posedge clk);
    #3;
    reset_central = 1'b1;
    #1;
    check_all_zero("async_reset");
    en = 1'b0;
    #2;
    reset_central = 1'b0;
    exp_q.delete();
    prev_ref = 0;
    @(posedge clk);
    #1;
    chk("async_release_contador", contador, 0);
    en = 1'b1;

    v.ra = 1; v.da = 5'd6; v.rb = 1; v.db = 5'd20;
    v.ga = 1; v.gb = 0; v.rf = 5'd0; run_period(v);
    v.ga = 0; v.gb = 1; v.rf = 5'd1; run_period(v);
    v.ga = 1; v.gb = 0; v.rf = 5'd2; run_period(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
